// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined adder/subtractor with valid/ready handshake.
// Operands are cut into LANE-bit segments. Each stage adds one segment and
// registers the carry, so the carry chain per cycle is only LANE bits long.
// Subtraction is x + ~y + 1: y is inverted and carry-in = sign at acceptance.
// A single global stall (advance) freezes every stage at once.
module add_sub_pipe #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             overflow
);
    localparam int STAGES = (LANE > 0) ? (WIDTH / LANE) : 1;

    if (LANE < 1 || LANE > WIDTH || (WIDTH % LANE) != 0) begin : g_bad_params
        $error("add_sub_pipe: WIDTH (%0d) must be a non-zero multiple of LANE (%0d)", WIDTH, LANE);
    end

    // Whole pipeline moves only when the output slot is empty or being drained.
    logic             advance;
    logic [WIDTH-1:0] b_inv;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_inv    = y ^ {WIDTH{sign}};

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // SW: result bits already produced after this stage.
        // RW: operand bits still waiting to be added by later stages.
        localparam int SW = (gi + 1) * LANE;
        localparam int RW = WIDTH - SW;

        logic [LANE-1:0] a_seg;
        logic [LANE-1:0] b_seg;
        logic            c_in;
        logic            v_in;
        logic            sa_in;
        logic            sb_in;
        logic [LANE:0]   seg_sum;
        logic [SW-1:0]   s_next;

        logic [SW-1:0]   s_reg;
        logic            c_reg;
        logic            v_reg;
        logic            sa_reg;
        logic            sb_reg;

        if (gi == 0) begin : g_src
            // First stage takes its segment and the sign bits straight from the ports.
            assign a_seg  = x[LANE-1:0];
            assign b_seg  = b_inv[LANE-1:0];
            assign c_in   = sign;
            assign v_in   = in_valid;
            assign sa_in  = x[WIDTH-1];
            assign sb_in  = b_inv[WIDTH-1];
            assign s_next = seg_sum[LANE-1:0];
        end else begin : g_src
            // Later stages consume the lowest remaining segment carried by the previous stage.
            assign a_seg  = g_stage[gi-1].g_pass.a_reg[LANE-1:0];
            assign b_seg  = g_stage[gi-1].g_pass.b_reg[LANE-1:0];
            assign c_in   = g_stage[gi-1].c_reg;
            assign v_in   = g_stage[gi-1].v_reg;
            assign sa_in  = g_stage[gi-1].sa_reg;
            assign sb_in  = g_stage[gi-1].sb_reg;
            assign s_next = {seg_sum[LANE-1:0], g_stage[gi-1].s_reg};
        end

        assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{LANE{1'b0}}, c_in};

        // Register this stage's partial sum, segment carry, valid and operand sign bits.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_reg  <= 1'b0;
                c_reg  <= 1'b0;
                s_reg  <= '0;
                sa_reg <= 1'b0;
                sb_reg <= 1'b0;
            end else if (advance) begin
                v_reg  <= v_in;
                c_reg  <= seg_sum[LANE];
                s_reg  <= s_next;
                sa_reg <= sa_in;
                sb_reg <= sb_in;
            end
        end

        if (RW > 0) begin : g_pass
            // Upper operand segments not yet added travel alongside the partial sum.
            logic [RW-1:0] a_rest;
            logic [RW-1:0] b_rest;
            logic [RW-1:0] a_reg;
            logic [RW-1:0] b_reg;

            if (gi == 0) begin : g_rest
                assign a_rest = x[WIDTH-1:LANE];
                assign b_rest = b_inv[WIDTH-1:LANE];
            end else begin : g_rest
                assign a_rest = g_stage[gi-1].g_pass.a_reg[RW+LANE-1:LANE];
                assign b_rest = g_stage[gi-1].g_pass.b_reg[RW+LANE-1:LANE];
            end

            // Shift pending operand segments forward; qualified by v_reg downstream so no reset needed.
            always_ff @(posedge clk) begin
                if (advance) begin
                    a_reg <= a_rest;
                    b_reg <= b_rest;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_reg;
    assign z         = g_stage[STAGES-1].s_reg;
    assign carry     = g_stage[STAGES-1].c_reg;
    // Same-sign operands producing a result of the other sign overflowed.
    assign overflow  = (g_stage[STAGES-1].sa_reg == g_stage[STAGES-1].sb_reg) &&
                       (z[WIDTH-1] != g_stage[STAGES-1].sa_reg);

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: directed vectors plus streaming, stall and reset sequences
// for a 32/8 instance and a single-stage 8/8 instance.
module tb_add_sub_pipe;

    logic        clk;
    logic        rst;

    // 32-bit, 4-stage instance
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        carry;
    logic        overflow;

    // 8-bit, single-stage instance
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic        sign8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  z8;
    logic        carry8;
    logic        overflow8;

    add_sub_pipe #(.WIDTH(32), .LANE(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .carry(carry), .overflow(overflow)
    );

    add_sub_pipe #(.WIDTH(8), .LANE(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .sign(sign8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .z(z8), .carry(carry8), .overflow(overflow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] ez;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs[10];

    logic [33:0] sb_q[$];
    logic        hold_pending;
    logic [33:0] held;
    int          n_in;
    int          n_out;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, want, $time);
        end
    endtask

    // Reference built from plain integer arithmetic: {overflow, carry, z}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] r;
        logic [32:0] w;
        logic        c;
        logic        o;
        longint      sa;
        longint      sbv;
        longint      sr;
        sa  = $signed(a);
        sbv = $signed(b);
        if (s) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sbv;
        end else begin
            w  = {1'b0, a} + {1'b0, b};
            r  = w[31:0];
            c  = w[32];
            sr = sa + sbv;
        end
        o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {o, c, r};
    endfunction

    // One clock of streaming with scoreboard and stall-hold checks; entered and left at #1 after a rising edge.
    task automatic cycle(input logic iv, input logic [31:0] xx, input logic [31:0] yy,
                         input logic ss, input logic ordy);
        logic [33:0] e;
        in_valid  = iv;
        x         = xx;
        y         = yy;
        sign      = ss;
        out_ready = ordy;
        #1;
        if (hold_pending) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_result", {30'd0, overflow, carry, z}, {30'd0, held});
        end
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            hold_pending = 1'b1;
            held = {overflow, carry, z};
        end else begin
            hold_pending = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("stream_z", {32'd0, z}, {32'd0, e[31:0]});
                chk("stream_flags", {62'd0, overflow, carry}, {62'd0, e[33:32]});
                $display("out #%0d z=%h carry=%b ovf=%b", n_out, z, carry, overflow);
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(model(xx, yy, ss));
            n_in++;
        end
        @(posedge clk);
        #1;
    endtask

    // Single operation on the 4-stage instance with exact latency check.
    task automatic single_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                             input logic [31:0] ez, input logic ec, input logic eo);
        in_valid  = 1'b1;
        x         = a;
        y         = b;
        sign      = s;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("latency_valid_%0d", i), {63'd0, out_valid}, {63'd0, (i == 3)});
        end
        chk("vec_z", {32'd0, z}, {32'd0, ez});
        chk("vec_carry", {63'd0, carry}, {63'd0, ec});
        chk("vec_overflow", {63'd0, overflow}, {63'd0, eo});
        $display("vec %h %s %h -> z=%h carry=%b ovf=%b", a, s ? "-" : "+", b, z, carry, overflow);
        @(posedge clk);
        #1;
        chk("vec_drained", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        hold_pending = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst = 1'b1;
        in_valid = 1'b0; x = '0; y = '0; sign = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; x8 = '0; y8 = '0; sign8 = 1'b0; out_ready8 = 1'b1;
        hold_pending = 1'b0; held = '0; n_in = 0; n_out = 0;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[2] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[5] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[6] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[7] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[9] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_z", {32'd0, z}, 64'd0);
        chk("rst_flags", {62'd0, overflow, carry}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_in_ready8", {63'd0, in_ready8}, 64'd1);

        // Directed vectors with latency
        foreach (vecs[i]) begin
            single_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ez, vecs[i].ec, vecs[i].eo);
        end

        // 8 back-to-back random operations: results on consecutive cycles from edge 3
        n_in = 0; n_out = 0;
        for (int c = 0; c < 13; c++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            cycle(c < 8, ra, rb, rs, 1'b1);
            chk($sformatf("b2b_valid_%0d", c), {63'd0, out_valid}, {63'd0, (c >= 3 && c < 11)});
        end
        chk("b2b_count", 64'(n_out), 64'd8);

        // Fill, stall 3 cycles, release
        n_in = 0; n_out = 0;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, 32'h01010101 * (c + 1), 32'h10000003 * c, c[0], 1'b1);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 32'hCAFE0004, 32'h0000BEEF, 1'b1, 1'b0);
        end
        cycle(1'b1, 32'hCAFE0004, 32'h0000BEEF, 1'b1, 1'b1);
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        chk("stall_in_count", 64'(n_in), 64'd5);
        chk("stall_out_count", 64'(n_out), 64'd5);
        chk("stall_queue_empty", 64'(sb_q.size()), 64'd0);
        chk("stall_drained", {63'd0, out_valid}, 64'd0);

        // Reset with 3 operations in flight
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 32'hAAAA0000 + c, 32'h00001111, 1'b0, 1'b1);
        end
        do_reset();
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        single_op(32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0);

        // Single-stage instance: latency 1
        x8 = 8'h7F; y8 = 8'h01; sign8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        chk("w8_valid", {63'd0, out_valid8}, 64'd1);
        chk("w8_z", {56'd0, z8}, 64'h80);
        chk("w8_flags", {62'd0, overflow8, carry8}, 64'b10);
        $display("w8 7f + 01 -> z=%h carry=%b ovf=%b", z8, carry8, overflow8);
        x8 = 8'h80; y8 = 8'h01; sign8 = 1'b1;
        @(posedge clk);
        #1;
        chk("w8_sub_z", {56'd0, z8}, 64'h7F);
        chk("w8_sub_flags", {62'd0, overflow8, carry8}, 64'b11);
        $display("w8 80 - 01 -> z=%h carry=%b ovf=%b", z8, carry8, overflow8);
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;
        chk("w8_bubble", {63'd0, out_valid8}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
# add_sub_pipe

Pipelined, parametrised successor to the combinational adder/subtractor. Operands are split into LANE-bit segments, one segment added per stage with the carry registered between stages, so the carry chain per cycle is LANE bits regardless of WIDTH. Each result carries carry-out and signed-overflow flags. It sits between operand sources and ALU result consumers behind a valid/ready handshake with full backpressure.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of LANE.
- LANE, 8, segment width per pipeline stage; STAGES = WIDTH/LANE.
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand pair presented
- in_ready  output  1  block accepts operands this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- sign  input  1  0 = add (x + y), 1 = subtract (x - y)
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result this cycle
- z  output  WIDTH  result, modulo 2^WIDTH
- carry  output  1  carry-out of bit WIDTH-1
- overflow  output  1  two's-complement overflow of the operation

## Operation
- Subtract is computed as x + ~y + 1: the inverted y and carry-in = sign are latched at acceptance.
- Stage k (0..STAGES-1) adds segment k of the operands with the carry from stage k-1 (stage 0 uses carry-in = sign). It registers the segment sum, carry-out and a valid bit. Upper operand segments travel with the stage.
- carry = carry-out of the final segment. For subtract, carry = 1 means no borrow (x >= y unsigned).
- overflow = (a[W-1] == b'[W-1]) && (z[W-1] != a[W-1]), where b' is y after conditional inversion.
- Global stall: advance = !out_valid || out_ready. When advance = 0, every stage holds data and valid.
- in_ready = advance. An operand pair is accepted only when in_valid && in_ready.
- Bubbles propagate as valid = 0. There is no compaction, so results leave strictly in acceptance order.
- A WIDTH that is not a multiple of LANE, or LANE > WIDTH, is an elaboration error ($error).
- No ordering or side effect exists between operations. The block is stateless apart from the pipeline registers.

## Timing
- Latency: a pair accepted at edge n has out_valid = 1 after edge n + STAGES - 1, i.e. STAGES cycles from in_valid && in_ready to out_valid, when not stalled.
- Throughput: one operation per cycle when out_ready is held at 1.
- LANE = WIDTH means STAGES = 1 and latency = 1 cycle.
- Reset: all stage valid bits, out_valid, z, carry and overflow are 0 on the edge where rst = 1. in_ready = 1 from the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded with no partial result. The first accept after reset produces the next output.
- Stall: while out_valid && !out_ready, z, carry and overflow are held bit-stable and in_ready = 0.
- Simultaneous output handshake and input accept in the same cycle are legal. The pipeline shifts by one with no bubble inserted.
- in_valid deasserting mid-stream inserts a bubble. Downstream results are unaffected.

## Test plan
- WIDTH=32, LANE=8: add 0xFFFFFFFF + 0x00000001 -> 4 cycles later z=0x00000000, carry=1, overflow=0.
- Subtract 0x80000000 - 0x00000001 -> z=0x7FFFFFFF, carry=1, overflow=1. Subtract 0x00000000 - 0x00000001 -> z=0xFFFFFFFF, carry=0, overflow=0.
- 8 back-to-back random add/sub pairs with out_ready=1 -> 8 results on consecutive cycles starting cycle 4, in order, each matching the model.
- Fill pipeline, then drop out_ready for 3 cycles -> in_ready=0 for those cycles, z held stable, no loss or duplication after release.
- Assert rst with 3 operations in flight -> out_valid=0 the next cycle, no stale result appears, and a subsequent 5 + 7 yields z=12 after 4 cycles.
- WIDTH=8, LANE=8: 0x7F + 0x01 -> z=0x80, overflow=1, carry=0 after 1 cycle.
